// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation/commit sequencer driving the alias table ports.
// In-order retirement, one per cycle; taken branch or exception flushes all.
module rob_alloc_ctrl #(
    parameter int ROB_DEPTH      = 8,
    parameter int GPR_ADDR_WIDTH = 5,
    localparam int TW            = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] dec_dst_addr,
    input  logic                      dec_dst_wen,
    output logic                      alloc_en,
    output logic [TW-1:0]             alloc_tag,
    output logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
    output logic                      alloc_dst_wen,
    input  logic                      wb_en,
    input  logic [TW-1:0]             wb_tag,
    input  logic                      wb_br_taken,
    input  logic                      wb_exp,
    output logic                      commit_en,
    output logic                      commit_dst_en,
    output logic [GPR_ADDR_WIDTH-1:0] commit_dst_addr,
    output logic [TW-1:0]             commit_Paddr,
    output logic                      commit_br_taken,
    output logic                      commit_exp_en,
    output logic [TW:0]               rob_count,
    output logic                      rob_full,
    output logic                      rob_empty
);

    typedef enum logic {RUN, FLUSH} state_e;

    localparam logic [TW:0] ONE      = (TW+1)'(1);
    localparam logic [TW:0] FULL_CNT = (TW+1)'(ROB_DEPTH);

    state_e                    state_q, state_d;
    logic [TW:0]               head_q, head_d;
    logic [TW:0]               tail_q, tail_d;
    logic [TW:0]               count_q, count_d;
    logic [ROB_DEPTH-1:0]      valid_q, done_q, wen_q, br_q, exp_q;
    logic [GPR_ADDR_WIDTH-1:0] dst_q [ROB_DEPTH];
    logic [TW-1:0]             hidx, tidx;
    logic                      run, flush_c;

    assign hidx = head_q[TW-1:0];
    assign tidx = tail_q[TW-1:0];
    assign run  = (state_q == RUN);

    assign rob_count = count_q;
    assign rob_full  = (count_q == FULL_CNT);
    assign rob_empty = (count_q == '0);

    // Commit outputs come purely from registered entry state.
    assign commit_en       = run & valid_q[hidx] & done_q[hidx];
    assign commit_dst_en   = commit_en & wen_q[hidx] & (dst_q[hidx] != '0);
    assign commit_dst_addr = dst_q[hidx];
    assign commit_Paddr    = hidx;
    assign commit_br_taken = commit_en & br_q[hidx];
    assign commit_exp_en   = commit_en & exp_q[hidx];
    assign flush_c         = commit_br_taken | commit_exp_en;

    assign dec_ready      = run & ~rob_full & ~flush_c;
    assign alloc_en       = dec_valid & dec_ready;
    assign alloc_tag      = tidx;
    assign alloc_dst_addr = dec_dst_addr;
    assign alloc_dst_wen  = dec_dst_wen;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_c) begin
            state_d = FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (state_q == FLUSH) state_d = RUN;
            if (alloc_en) tail_d = tail_q + ONE;
            if (commit_en) head_d = head_q + ONE;
            unique case ({alloc_en, commit_en})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Alloc is applied last so it always wins over a stray writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            wen_q   <= '0;
            br_q    <= '0;
            exp_q   <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) dst_q[i] <= '0;
        end else if (flush_c) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (wb_en && valid_q[wb_tag]) begin
                done_q[wb_tag] <= 1'b1;
                br_q[wb_tag]   <= wb_br_taken;
                exp_q[wb_tag]  <= wb_exp;
            end
            if (commit_en) valid_q[hidx] <= 1'b0;
            if (alloc_en) begin
                valid_q[tidx] <= 1'b1;
                done_q[tidx]  <= 1'b0;
                br_q[tidx]    <= 1'b0;
                exp_q[tidx]   <= 1'b0;
                wen_q[tidx]   <= dec_dst_wen;
                dst_q[tidx]   <= dec_dst_addr;
            end
        end
    end

endmodule

// File: doc/rob_alloc_ctrl.md
# rob_alloc_ctrl

Reorder-buffer allocation and commit sequencer that owns the ROB pointers and drives the register alias table's allocate, commit and flush ports. It accepts one decoded instruction per cycle from the decode stage and hands out a ROB tag, which the alias table uses as the physical address. It records completion from writeback and retires the oldest completed entry in order, one per cycle. On retirement of a taken branch or an exception it flushes all in-flight state and holds decode off for one cycle.

## Interface
- ROB_DEPTH, 8, number of ROB entries (power of two, ≥2); TW = $clog2(ROB_DEPTH)
- GPR_ADDR_WIDTH, 5, architectural register address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  controller can accept
- dec_dst_addr  in  GPR_ADDR_WIDTH  destination architectural register
- dec_dst_wen  in  1  instruction writes a destination
- alloc_en  out  1  dec_valid & dec_ready; to alias table and ROB
- alloc_tag  out  TW  tail index assigned to the instruction
- alloc_dst_addr  out  GPR_ADDR_WIDTH  pass-through of dec_dst_addr
- alloc_dst_wen  out  1  pass-through of dec_dst_wen
- wb_en  in  1  execution result complete
- wb_tag  in  TW  completing entry
- wb_br_taken  in  1  completing entry is a taken branch
- wb_exp  in  1  completing entry raised an exception
- commit_en  out  1  head entry retires this cycle
- commit_dst_en  out  1  commit_en & head dst_wen & (head dst_addr != 0)
- commit_dst_addr  out  GPR_ADDR_WIDTH  head destination
- commit_Paddr  out  TW  head index
- commit_br_taken  out  1  commit_en & head br_taken
- commit_exp_en  out  1  commit_en & head exp
- rob_count  out  TW+1  occupied entries
- rob_full  out  1  rob_count == ROB_DEPTH
- rob_empty  out  1  rob_count == 0

## Operation
- Per-entry state: valid, done, dst_addr, dst_wen, br_taken, exp. Pointers head and tail are TW+1 bits, with the MSB used as the wrap bit. Empty when head == tail. Full when the low bits are equal and the MSBs differ.
- FSM states: RUN and FLUSH.
  - RUN → FLUSH when the commit is a flush commit (commit_br_taken | commit_exp_en).
  - FLUSH → RUN unconditionally after one cycle.
- dec_ready = (state == RUN) & !rob_full & !(commit_br_taken | commit_exp_en).
- Allocate (alloc_en): the entry at tail[TW-1:0] gets valid=1, done=0, br_taken=0, exp=0, and stores dst fields. tail increments modulo 2·ROB_DEPTH.
- Writeback: if wb_en and entry[wb_tag].valid, then done=1 and br_taken/exp are latched. A writeback to an invalid entry is ignored.
- Commit: commit_en = (state == RUN) & entry[head].valid & entry[head].done. All commit outputs are combinational from registered entry state. On commit, the head entry's valid is cleared and head increments.
- Flush commit: at the clock edge, every entry's valid and done are cleared, head = tail = 0, and rob_count = 0. Any alloc or writeback in that cycle is discarded.
- rob_count is registered. It is +1 on alloc only, −1 on commit only, unchanged on both, and 0 on a flush.

## Timing
- Reset values: state=RUN, head=tail=0, all entries invalid. dec_ready=1, alloc_en=0, commit_* all 0, rob_count=0, rob_empty=1, rob_full=0.
- Allocation is 0 cycles: alloc_tag is valid in the same cycle as the dec_valid & dec_ready handshake.
- Writeback to commit latency is 1 cycle minimum. A wb_en on the head entry in cycle N gives commit_en in cycle N+1, never in N.
- A full ROB does not bypass a same-cycle commit. dec_ready stays low until the cycle after the commit registers.
- Alloc and a non-flush commit in the same cycle are both performed, including the wrap-around of tail/head from index ROB_DEPTH−1 to 0.
- After a flush commit in cycle N: cycle N+1 is FLUSH with dec_ready=0 and commit_en=0. Cycle N+2 is RUN with an empty ROB and dec_ready=1.
- Asynchronous reset in any state, including mid-flush, returns all outputs to their reset values immediately.

## Test plan
- Fill: ROB_DEPTH=8, dec_valid held high, no writeback → 8 allocs with tags 0..7, then dec_ready=0, rob_full=1, rob_count=8.
- In-order commit: allocate tags 0,1,2 (dst x5, x6, x0 with wen=1) and write back 2,1,0 in successive cycles → commits occur in order 0,1,2. Tag 2 has commit_dst_en=0 because its destination is x0.
- Full plus simultaneous: with the ROB full, write back tag 0 → commit_en next cycle, rob_count goes 8→7, dec_ready=1 one cycle after the commit. A simultaneous alloc+commit then keeps rob_count=7 and tail wraps to index 0.
- Branch flush: 4 entries in flight, tag 1 written back with wb_br_taken=1, tag 0 done → commit tag 0, then tag 1 with commit_br_taken=1. The next cycle has dec_ready=0 and rob_count=0, the cycle after has dec_ready=1, and the next alloc_tag=0.
- Exception versus writeback: commit_exp_en asserted in the same cycle as wb_en to a younger tag and dec_valid=1 → no alloc occurs, and the younger entry is not done after the flush.
- Reset mid-flush: assert rst_n=0 during the FLUSH state → all outputs at reset values immediately. After release, dec_ready=1.
